// File: rtl/fifomem_mc.sv
// Multi-channel single-clock FIFO: NCHAN queues share one partitioned memory.
// Ports: clk, rst (sync, active-high); wen/wchan/wdata; ren/rchan;
//        rdata/rvalid; full/empty/count per channel; overflow/underflow; clr_err.
module fifomem_mc #(
  parameter  int DATASIZE = 8,
  parameter  int ADDRSIZE = 4,
  parameter  int NCHAN    = 4,
  localparam int CHSIZE   = $clog2(NCHAN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wen,
  input  logic [CHSIZE-1:0]            wchan,
  input  logic [DATASIZE-1:0]          wdata,
  input  logic                         ren,
  input  logic [CHSIZE-1:0]            rchan,
  output logic [DATASIZE-1:0]          rdata,
  output logic                         rvalid,
  output logic [NCHAN-1:0]             full,
  output logic [NCHAN-1:0]             empty,
  output logic [NCHAN*(ADDRSIZE+1)-1:0] count,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         clr_err
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam int PW    = ADDRSIZE + 1;
  localparam int AW    = CHSIZE + ADDRSIZE;

  logic [DATASIZE-1:0] r_mem [NCHAN*DEPTH];
  logic [PW-1:0]       r_wptr [NCHAN];
  logic [PW-1:0]       r_rptr [NCHAN];
  logic [DATASIZE-1:0] r_rdata;
  logic                r_rvalid;
  logic                r_ovf;
  logic                r_unf;

  logic                w_wchan_ok;
  logic                w_rchan_ok;
  logic                w_wr_ok;
  logic                w_rd_ok;
  logic                w_wr_drop;
  logic                w_rd_drop;
  logic [AW-1:0]       w_waddr;
  logic [AW-1:0]       w_raddr;

  // Channel indices beyond NCHAN only exist when NCHAN is not a power of 2.
  generate
    if ((1 << CHSIZE) == NCHAN) begin : g_pow2
      assign w_wchan_ok = 1'b1;
      assign w_rchan_ok = 1'b1;
    end else begin : g_npow2
      assign w_wchan_ok = int'(wchan) < NCHAN;
      assign w_rchan_ok = int'(rchan) < NCHAN;
    end
  endgenerate

  always_comb begin
    full  = '0;
    empty = '0;
    count = '0;
    for (int i = 0; i < NCHAN; i++) begin
      empty[i] = (r_wptr[i] == r_rptr[i]);
      full[i]  = (r_wptr[i][ADDRSIZE] != r_rptr[i][ADDRSIZE]) &&
                 (r_wptr[i][ADDRSIZE-1:0] == r_rptr[i][ADDRSIZE-1:0]);
      count[i*PW +: PW] = r_wptr[i] - r_rptr[i];
    end
  end

  // Accept decisions use start-of-cycle flags, so a same-channel
  // read/write pair never bypasses through the memory.
  assign w_wr_ok   = wen & w_wchan_ok & ~full[wchan];
  assign w_rd_ok   = ren & w_rchan_ok & ~empty[rchan];
  assign w_wr_drop = wen & w_wchan_ok &  full[wchan];
  assign w_rd_drop = ren & w_rchan_ok &  empty[rchan];

  assign w_waddr = {wchan, r_wptr[wchan][ADDRSIZE-1:0]};
  assign w_raddr = {rchan, r_rptr[rchan][ADDRSIZE-1:0]};

  always_ff @(posedge clk) begin
    if (!rst && w_wr_ok) begin
      r_mem[w_waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCHAN; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
      end
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wptr[wchan] <= r_wptr[wchan] + PW'(1);
      end
      if (w_rd_ok) begin
        r_rptr[rchan] <= r_rptr[rchan] + PW'(1);
        r_rdata       <= r_mem[w_raddr];
      end
      r_rvalid <= w_rd_ok;
      if (w_wr_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_err) begin
        r_ovf <= 1'b0;
      end
      if (w_rd_drop) begin
        r_unf <= 1'b1;
      end else if (clr_err) begin
        r_unf <= 1'b0;
      end
    end
  end

  assign rdata     = r_rdata;
  assign rvalid    = r_rvalid;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_fifomem_mc.sv
// Scoreboard bench for fifomem_mc: per-channel queue model, read-data queue.
// Checks flags, counts, errors and read data every cycle.
module tb_fifomem_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wen = 1'b0;
  logic [1:0]  wchan = '0;
  logic [7:0]  wdata = '0;
  logic        ren = 1'b0;
  logic [1:0]  rchan = '0;
  logic [7:0]  rdata;
  logic        rvalid;
  logic [3:0]  full;
  logic [3:0]  empty;
  logic [19:0] count;
  logic        overflow;
  logic        underflow;
  logic        clr_err = 1'b0;

  fifomem_mc #(.DATASIZE(8), .ADDRSIZE(4), .NCHAN(4)) dut (
    .clk(clk), .rst(rst),
    .wen(wen), .wchan(wchan), .wdata(wdata),
    .ren(ren), .rchan(rchan),
    .rdata(rdata), .rvalid(rvalid),
    .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic [7:0] mq [4][$];
  logic [7:0] sb [$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic [7:0] m_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_state();
    logic [3:0]  e_full;
    logic [3:0]  e_empty;
    logic [19:0] e_cnt;
    for (int i = 0; i < 4; i++) begin
      e_full[i]  = (mq[i].size() == 16);
      e_empty[i] = (mq[i].size() == 0);
      e_cnt[i*5 +: 5] = 5'(mq[i].size());
    end
    chk("full", 32'(full), 32'(e_full));
    chk("empty", 32'(empty), 32'(e_empty));
    chk("count", 32'(count), 32'(e_cnt));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    chk("rdata_hold", 32'(rdata), 32'(m_rdata));
  endtask

  task automatic step(input logic w, input logic [1:0] wc,
                      input logic [7:0] wd, input logic r,
                      input logic [1:0] rc, input logic c);
    logic f_m;
    logic e_m;
    logic e_rv;
    wen = w; wchan = wc; wdata = wd;
    ren = r; rchan = rc; clr_err = c;
    f_m  = (mq[wc].size() == 16);
    e_m  = (mq[rc].size() == 0);
    e_rv = r && !e_m;
    if (e_rv) begin
      m_rdata = mq[rc].pop_front();
      sb.push_back(m_rdata);
    end
    if (w && !f_m) mq[wc].push_back(wd);
    if (w && f_m) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    if (r && e_m) m_unf = 1'b1;
    else if (c) m_unf = 1'b0;
    @(posedge clk);
    #1;
    wen = 1'b0; ren = 1'b0; clr_err = 1'b0;
    chk("rvalid", 32'(rvalid), 32'(e_rv));
    if (rvalid) begin
      if (sb.size() == 0) chk("sb_underrun", 32'd1, 32'd0);
      else chk("rdata", 32'(rdata), 32'(sb.pop_front()));
    end
    chk_state();
  endtask

  task automatic do_reset(input logic r, input logic [1:0] rc);
    rst = 1'b1; ren = r; rchan = rc; wen = 1'b0; clr_err = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0; ren = 1'b0;
    for (int i = 0; i < 4; i++) mq[i].delete();
    sb.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_rdata = '0;
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk_state();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk);
    do_reset(1'b0, 2'd0);
    repeat (3) step(0, 0, 0, 0, 0, 0);

    step(1, 2, 8'h11, 0, 0, 0);
    step(1, 2, 8'h22, 0, 0, 0);
    step(1, 2, 8'h33, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 16; k++) step(1, 1, 8'(k), 0, 0, 0);
    step(1, 1, 8'hAA, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 16; k++) step(0, 0, 0, 1, 1, 0);

    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 16; k++)
        step(1, 0, 8'($urandom), (k < 2) && (mq[3].size() > 0), 3, 0);
      for (int k = 0; k < 16; k++)
        step(k < 2, 3, 8'($urandom), 1, 0, 0);
    end
    while (mq[3].size() > 0) step(0, 0, 0, 1, 3, 0);

    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 8'h5A, 1, 0, 0);
    for (int k = 0; k < 15; k++) step(1, 0, 8'(8'h80 + k), 0, 0, 0);
    step(1, 0, 8'hEE, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 7; k++) step(0, 0, 0, 1, 0, 0);
    step(1, 0, 8'h77, 1, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 1, 0, 0);

    for (int k = 0; k < 5; k++) step(1, 1, 8'(8'hC0 + k), 0, 0, 0);
    do_reset(1'b1, 2'd1);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1);

    for (int k = 0; k < 16; k++) step(1, 1, 8'(8'h40 + k), 0, 0, 0);
    step(1, 1, 8'hBB, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 16; k++) step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fifomem_mc.md
Name: fifomem_mc

Overview:
Single-clock, multi-channel FIFO buffer. NCHAN independent queues share one memory array that is statically partitioned into NCHAN regions of DEPTH entries each. Every channel has its own read and write pointers, full and empty flags, and occupancy count. Read data is registered and qualified by a valid strobe. It is the building block for the multi-stream buffering stages in front of the asynchronous FIFO path.

Parameters:
DATASIZE, 8, data word width in bits
ADDRSIZE, 4, per-channel address width; DEPTH = 1<<ADDRSIZE entries per channel
NCHAN, 4, number of channels; must be >= 2
CHSIZE, $clog2(NCHAN), channel-select width (derived localparam)

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  synchronous reset, active-high
wen  in  1  write request
wchan  in  CHSIZE  channel selected for the write
wdata  in  DATASIZE  write data
ren  in  1  read request
rchan  in  CHSIZE  channel selected for the read
rdata  out  DATASIZE  registered read data
rvalid  out  1  one-cycle strobe; rdata is valid
full  out  NCHAN  per-channel full flag, bit i is channel i
empty  out  NCHAN  per-channel empty flag
count  out  NCHAN*(ADDRSIZE+1)  per-channel occupancy, channel i at bits [i*(ADDRSIZE+1) +: ADDRSIZE+1]
overflow  out  1  sticky: a write to a full channel was dropped
underflow  out  1  sticky: a read from an empty channel was dropped
clr_err  in  1  clears overflow and underflow

Behaviour:
- Reset: one clock-synchronous reset, active-high, on port rst, sampled on posedge clk.
- On reset:
  - all wptr/rptr = 0; empty = all 1s; full = all 0s; count = all 0.
  - rvalid = 0; rdata = 0; overflow = 0; underflow = 0.
  - Memory contents are not reset.
  - Reset takes priority over every other input in the same cycle; a request in the reset cycle is discarded.
- Pointers:
  - Each channel has wptr[i] and rptr[i], each ADDRSIZE+1 bits. The MSB is the wrap bit.
  - Physical address = {chan, ptr[ADDRSIZE-1:0]}. The memory holds NCHAN*DEPTH words.
- Flags (combinational from registered pointers):
  - empty[i] = (wptr[i] == rptr[i]).
  - full[i] = (MSBs differ && low bits equal).
  - count[i] = wptr[i] - rptr[i], modulo 2^(ADDRSIZE+1); range 0..DEPTH.
- Write accept: wen && !full[wchan], where full is the value at the start of the cycle.
  - Accepted: mem <= wdata; wptr[wchan] += 1.
  - Rejected: no pointer or memory change; overflow <= 1.
- Read accept: ren && !empty[rchan], where empty is the value at the start of the cycle.
  - Accepted: rdata <= mem[{rchan, rptr low bits}]; rptr[rchan] += 1; rvalid <= 1 on the next edge. Latency is 1 cycle.
  - Rejected: rvalid <= 0, rdata holds, underflow <= 1.
- No read: rvalid <= 0; rdata holds its last value.
- Simultaneous read and write, different channels: both proceed independently.
- Simultaneous read and write, same channel:
  - Both are judged on start-of-cycle flags.
  - Empty channel: the read is rejected (underflow) and the write is accepted. There is no write-through bypass.
  - Full channel: the write is rejected (overflow) and the read is accepted.
  - Otherwise both are accepted and count is unchanged.
- Wrap-around: pointers increment modulo 2^(ADDRSIZE+1). The low bits wrap within the channel's own region and never touch another channel's region.
- Errors:
  - clr_err clears overflow and underflow in the next cycle.
  - If a new error event occurs in the same cycle as clr_err, the error event wins and the flag is set.
- Out-of-range channel index (NCHAN not a power of 2, chan >= NCHAN): the request is ignored and no error flag is set.
- Throughput: one write and one read per cycle with no bubbles.

Test Plan:
- Reset, then idle 3 cycles -> empty=4'b1111, full=0, count all 0, rvalid=0, rdata=0, no error flags.
- Write 0x11,0x22,0x33 to ch2, then read ch2 three cycles back-to-back -> rvalid high for 3 cycles starting 1 cycle after the first ren; rdata 0x11,0x22,0x33; count[2] goes 3 then 0; empty[2]=1.
- Fill ch1 with 16 words (0x00..0x0F) -> full[1]=1, count[1]=16; other channels still empty. A 17th write is dropped and overflow=1. Draining ch1 returns 0x00..0x0F exactly.
- Repeat fill/drain of ch0 40 times, interleaved with writes to ch3 -> pointers wrap; data is intact; ch3 data is uncorrupted; counts are correct throughout.
- Read and write in the same cycle:
  - Empty ch0 -> write accepted, read rejected, underflow=1, rvalid=0.
  - Full ch0 -> read accepted, write rejected, overflow=1, count stays 16 then 15.
  - Half-full ch0 -> count unchanged.
- Assert rst mid-stream with ch1 holding 5 entries and ren high -> next cycle count=0, empty all 1, rvalid=0. Assert clr_err in the same cycle as an overflow -> overflow remains 1.
